ifmap_streamer: RTL and testbench

IFMAP_STREAMER -- requirements
Module: ifmap_streamer

---
 rtl/ifmap_streamer.sv | 121 ++++++++++++
 tb/tb_ifmap_streamer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_streamer.sv
// Streams num_ch row-major W*H pixel frames from feature memory to the conv core,
// handshaking each frame with o_conv_start / i_conv_done.
module ifmap_streamer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic [8:0]            i_width,
   input  logic [8:0]            i_height,
   input  logic [9:0]            i_num_ch,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   input  logic                  i_abort,
   output logic                  o_mem_en,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   output logic                  o_conv_start,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_data_valid,
   output logic [9:0]            o_ch,
   input  logic                  i_conv_done,
   output logic                  o_cmd_done,
   output logic                  o_err
);

   typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_DONE} state_t;

   state_t                state, state_nxt;
   logic [8:0]            width_q, height_q;
   logic [9:0]            num_ch_q, ch_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [17:0]           rd_cnt, npix;
   logic                  rd_vld, err_q, done_q;
   logic                  cmd_fire, cmd_bad, last_ch, abort_act, frame_done;

   assign npix       = 18'(width_q) * 18'(height_q);
   assign cmd_fire   = i_cmd_valid && o_cmd_ready;
   assign cmd_bad    = (i_width == 9'd0) || (i_height == 9'd0) || (i_num_ch == 10'd0);
   assign last_ch    = (ch_q == num_ch_q - 10'd1);
   assign abort_act  = i_abort && (state != IDLE);
   assign frame_done = (state == WAIT_DONE) && i_conv_done && !i_abort;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      o_cmd_ready  = 1'b0;
      o_conv_start = 1'b0;
      o_mem_en     = 1'b0;
      case (state)
         IDLE: begin
            o_cmd_ready = 1'b1;
            if (cmd_fire && !cmd_bad) state_nxt = START;
         end
         START: begin
            o_conv_start = 1'b1;
            o_mem_en     = 1'b1;
            state_nxt    = STREAM;
         end
         STREAM: begin
            // The cycle with no read left to issue carries the last pixel.
            if (rd_cnt != npix) o_mem_en  = 1'b1;
            else                state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (i_conv_done) state_nxt = last_ch ? IDLE : START;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort_act) state_nxt = IDLE;
   end

   // addr_q runs on across frames, so after a frame it already holds base + W*H.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         width_q  <= '0;
         height_q <= '0;
         num_ch_q <= '0;
         ch_q     <= '0;
         addr_q   <= '0;
         rd_cnt   <= '0;
         rd_vld   <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         err_q  <= cmd_fire && cmd_bad;
         done_q <= frame_done && last_ch;
         rd_vld <= o_mem_en && !abort_act;
         if (o_mem_en) begin
            addr_q <= addr_q + 1'b1;
            rd_cnt <= rd_cnt + 18'd1;
         end
         if (cmd_fire && !cmd_bad) begin
            width_q  <= i_width;
            height_q <= i_height;
            num_ch_q <= i_num_ch;
            addr_q   <= i_base_addr;
            ch_q     <= '0;
            rd_cnt   <= '0;
         end
         if (frame_done) begin
            rd_cnt <= '0;
            ch_q   <= last_ch ? 10'd0 : ch_q + 10'd1;
         end
         if (abort_act) ch_q <= '0;
      end
   end

   assign o_mem_addr   = o_mem_en ? addr_q : '0;
   assign o_data_valid = rd_vld;
   assign o_data       = rd_vld ? i_mem_rdata : '0;
   assign o_ch         = ch_q;
   assign o_cmd_done   = done_q;
   assign o_err        = err_q;

endmodule

// File: tb/tb_ifmap_streamer.sv
// Directed bench for ifmap_streamer; memory returns pix(addr) one cycle after a read.
module tb_ifmap_streamer;
   localparam int DW = 16;
   localparam int AW = 16;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_cmd_valid = 1'b0;
   logic          o_cmd_ready;
   logic [8:0]    i_width = '0;
   logic [8:0]    i_height = '0;
   logic [9:0]    i_num_ch = '0;
   logic [AW-1:0] i_base_addr = '0;
   logic          i_abort = 1'b0;
   logic          o_mem_en;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] i_mem_rdata;
   logic          o_conv_start;
   logic [DW-1:0] o_data;
   logic          o_data_valid;
   logic [9:0]    o_ch;
   logic          i_conv_done = 1'b0;
   logic          o_cmd_done;
   logic          o_err;

   int errors = 0;
   int checks = 0;

   ifmap_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_width(i_width), .i_height(i_height), .i_num_ch(i_num_ch), .i_base_addr(i_base_addr),
      .i_abort(i_abort), .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .i_mem_rdata(i_mem_rdata),
      .o_conv_start(o_conv_start), .o_data(o_data), .o_data_valid(o_data_valid), .o_ch(o_ch),
      .i_conv_done(i_conv_done), .o_cmd_done(o_cmd_done), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
      return a ^ 16'h5A3C;
   endfunction

   always @(posedge i_clk) i_mem_rdata <= o_mem_en ? pix(o_mem_addr) : 16'hDEAD;

   task automatic step;
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [8:0] w, input logic [8:0] h, input logic [9:0] n,
                       input logic [AW-1:0] b);
      i_width = w; i_height = h; i_num_ch = n; i_base_addr = b;
      i_cmd_valid = 1'b1;
      step;
      i_cmd_valid = 1'b0;
   endtask

   // Entered in the START cycle; leaves in the first WAIT_DONE cycle.
   task automatic stream_frame(input logic [AW-1:0] b, input int n, input logic [9:0] exp_ch);
      logic [AW-1:0] a;
      checks++;
      if ({o_conv_start, o_mem_en, o_data_valid, o_cmd_ready} !== 4'b1100 || o_mem_addr !== b || o_ch !== exp_ch) begin
         errors++;
         $display("FAIL frame_start: start/en/vld/rdy=%b addr=%h ch=%0d, want 1100 addr=%h ch=%0d",
                  {o_conv_start, o_mem_en, o_data_valid, o_cmd_ready}, o_mem_addr, o_ch, b, exp_ch);
      end
      for (int i = 0; i < n; i++) begin
         a = b + AW'(i);
         step;
         checks++;
         if (o_data_valid !== 1'b1 || o_conv_start !== 1'b0 || o_data !== pix(a)) begin
            errors++;
            $display("FAIL pixel %0d: vld=%b start=%b data=%h, want 1 0 %h", i, o_data_valid, o_conv_start, o_data, pix(a));
         end
         checks++;
         if (i < n - 1) begin
            if (o_mem_en !== 1'b1 || o_mem_addr !== a + 16'd1) begin
               errors++;
               $display("FAIL read %0d: en=%b addr=%h, want 1 %h", i + 1, o_mem_en, o_mem_addr, a + 16'd1);
            end
         end else if (o_mem_en !== 1'b0) begin
            errors++;
            $display("FAIL read_stop: en=%b, want 0", o_mem_en);
         end
      end
      step;
      checks++;
      if ({o_data_valid, o_mem_en, o_cmd_done, o_cmd_ready} !== 4'b0000 || o_data !== 16'h0) begin
         errors++;
         $display("FAIL wait_done: vld/en/done/rdy=%b data=%h, want 0000 0000",
                  {o_data_valid, o_mem_en, o_cmd_done, o_cmd_ready}, o_data);
      end
   endtask

   task automatic finish_cmd;
      i_conv_done = 1'b1;
      step;
      i_conv_done = 1'b0;
      checks++;
      if ({o_cmd_ready, o_cmd_done, o_conv_start} !== 3'b110) begin
         errors++;
         $display("FAIL cmd_done: rdy/done/start=%b, want 110", {o_cmd_ready, o_cmd_done, o_conv_start});
      end
      step;
      checks++;
      if ({o_cmd_ready, o_cmd_done} !== 2'b10) begin
         errors++;
         $display("FAIL done_pulse: rdy/done=%b, want 10", {o_cmd_ready, o_cmd_done});
      end
   endtask

   task automatic test_reset;
      i_rst = 1'b1;
      step; step;
      checks++;
      if ({o_cmd_ready, o_conv_start, o_mem_en, o_data_valid, o_cmd_done, o_err} !== 6'b100000 ||
          o_data !== 16'h0 || o_mem_addr !== 16'h0 || o_ch !== 10'd0) begin
         errors++;
         $display("FAIL reset: flags=%b data=%h addr=%h ch=%0d, want 100000 0 0 0",
                  {o_cmd_ready, o_conv_start, o_mem_en, o_data_valid, o_cmd_done, o_err}, o_data, o_mem_addr, o_ch);
      end
      i_rst = 1'b0;
      step;
   endtask

   task automatic test_single;
      send(9'd4, 9'd4, 10'd1, 16'h0100);
      stream_frame(16'h0100, 16, 10'd0);
      step;
      checks++;
      if ({o_cmd_ready, o_cmd_done, o_conv_start} !== 3'b000) begin
         errors++;
         $display("FAIL hold_wait: rdy/done/start=%b, want 000", {o_cmd_ready, o_cmd_done, o_conv_start});
      end
      finish_cmd;
   endtask

   task automatic test_two_ch;
      send(9'd4, 9'd4, 10'd2, 16'h0100);
      stream_frame(16'h0100, 16, 10'd0);
      i_conv_done = 1'b1;
      step;
      i_conv_done = 1'b0;
      checks++;
      if (o_cmd_done !== 1'b0) begin
         errors++;
         $display("FAIL early_done: done=%b, want 0", o_cmd_done);
      end
      stream_frame(16'h0110, 16, 10'd1);
      finish_cmd;
   endtask

   task automatic test_reject;
      logic [8:0] w [3] = '{9'd0, 9'd4, 9'd4};
      logic [8:0] h [3] = '{9'd4, 9'd0, 9'd4};
      logic [9:0] n [3] = '{10'd1, 10'd1, 10'd0};
      for (int k = 0; k < 3; k++) begin
         send(w[k], h[k], n[k], 16'h0100);
         checks++;
         if ({o_err, o_cmd_ready, o_conv_start, o_mem_en} !== 4'b1100) begin
            errors++;
            $display("FAIL reject %0d: err/rdy/start/en=%b, want 1100", k, {o_err, o_cmd_ready, o_conv_start, o_mem_en});
         end
         step;
         checks++;
         if ({o_err, o_cmd_ready, o_conv_start, o_mem_en} !== 4'b0100) begin
            errors++;
            $display("FAIL reject_after %0d: err/rdy/start/en=%b, want 0100", k, {o_err, o_cmd_ready, o_conv_start, o_mem_en});
         end
      end
   endtask

   task automatic test_wrap;
      send(9'd4, 9'd4, 10'd1, 16'hFFF8);
      stream_frame(16'hFFF8, 16, 10'd0);
      finish_cmd;
   endtask

   task automatic test_one_pixel;
      send(9'd1, 9'd1, 10'd1, 16'h0042);
      stream_frame(16'h0042, 1, 10'd0);
      finish_cmd;
   endtask

   task automatic test_abort;
      send(9'd4, 9'd4, 10'd1, 16'h0200);
      for (int i = 0; i <= 5; i++) begin
         i_conv_done = (i == 2);
         step;
         checks++;
         if (o_data_valid !== 1'b1 || o_data !== pix(16'h0200 + 16'(i))) begin
            errors++;
            $display("FAIL abort_px %0d: vld=%b data=%h, want 1 %h", i, o_data_valid, o_data, pix(16'h0200 + 16'(i)));
         end
      end
      i_conv_done = 1'b0;
      i_abort = 1'b1;
      step;
      i_abort = 1'b0;
      checks++;
      if ({o_cmd_ready, o_data_valid, o_mem_en, o_cmd_done} !== 4'b1000 || o_data !== 16'h0) begin
         errors++;
         $display("FAIL abort: rdy/vld/en/done=%b data=%h, want 1000 0000",
                  {o_cmd_ready, o_data_valid, o_mem_en, o_cmd_done}, o_data);
      end
      step;
      checks++;
      if (o_cmd_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_nodone: done=%b, want 0", o_cmd_done);
      end
      send(9'd2, 9'd3, 10'd1, 16'h0300);
      stream_frame(16'h0300, 6, 10'd0);
      finish_cmd;
   endtask

   task automatic test_abort_vs_done;
      send(9'd1, 9'd1, 10'd1, 16'h0010);
      stream_frame(16'h0010, 1, 10'd0);
      i_conv_done = 1'b1;
      i_abort = 1'b1;
      step;
      i_conv_done = 1'b0;
      i_abort = 1'b0;
      checks++;
      if ({o_cmd_ready, o_cmd_done} !== 2'b10) begin
         errors++;
         $display("FAIL abort_prio: rdy/done=%b, want 10", {o_cmd_ready, o_cmd_done});
      end
      step;
      checks++;
      if (o_cmd_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_prio_late: done=%b, want 0", o_cmd_done);
      end
   endtask

   task automatic test_rst_stream;
      send(9'd4, 9'd4, 10'd1, 16'h0400);
      step; step; step;
      i_rst = 1'b1;
      step;
      checks++;
      if ({o_cmd_ready, o_conv_start, o_mem_en, o_data_valid, o_cmd_done, o_err} !== 6'b100000 ||
          o_data !== 16'h0 || o_mem_addr !== 16'h0 || o_ch !== 10'd0) begin
         errors++;
         $display("FAIL rst_stream: flags=%b data=%h addr=%h ch=%0d, want 100000 0 0 0",
                  {o_cmd_ready, o_conv_start, o_mem_en, o_data_valid, o_cmd_done, o_err}, o_data, o_mem_addr, o_ch);
      end
      i_rst = 1'b0;
      step;
      send(9'd2, 9'd2, 10'd1, 16'h0500);
      stream_frame(16'h0500, 4, 10'd0);
      finish_cmd;
   endtask

   initial begin
      test_reset;
      test_single;
      test_two_ch;
      test_reject;
      test_wrap;
      test_one_pixel;
      test_abort;
      test_abort_vs_done;
      test_rst_stream;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench still running at %0t", $time);
      $fatal(1, "timeout");
   end
endmodule
